// File: rtl/ga25_sdr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ga25_sdr_arbiter_pkg
// Brief    : Shared widths and arbiter state encoding for the SDRAM read arbiter
// Revision : 1.0 - initial release
// ============================================================================
package ga25_sdr_arbiter_pkg;

  localparam int SDR_ADDR_W = 25;
  localparam int SDR_DATA_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RETURN  = 3'd3,
    ST_REFRESH = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ga25_sdr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : ga25_rr_picker
// Brief    : Rotating priority encoder; first set request at or after ptr wins
// Revision : 1.0 - initial release
// ============================================================================
module ga25_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  int               w_pos;
  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest slot back to ptr so the nearest requester wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_pos = 0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_idx = IDX_W'(w_pos);
      if (req[w_idx]) begin
        grant = w_idx;
        any   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ga25_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ga25_sdr_arbiter
// Brief    : Round-robin arbiter sharing one SDRAM read channel among clients,
//            with idle-time refresh merging. GA25_ARB_TIMEOUT_EN adds a WAIT
//            timeout and the sticky timeout_seen output.
// Revision : 1.0 - initial release
// ============================================================================
module ga25_sdr_arbiter
  import ga25_sdr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk_ram,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            cl_req,
  input  logic [NUM_REQ*SDR_ADDR_W-1:0] cl_addr,
  input  logic [NUM_REQ-1:0]            cl_refresh,
  output logic [NUM_REQ-1:0]            cl_rdy,
  output logic [SDR_DATA_W-1:0]         cl_data,
  output logic [SDR_ADDR_W-1:0]         sdr_addr,
  output logic                          sdr_req,
  input  logic                          sdr_rdy,
  input  logic [SDR_DATA_W-1:0]         sdr_data,
  output logic                          sdr_refresh,
`ifdef GA25_ARB_TIMEOUT_EN
  output logic                          timeout_seen,
`endif
  output logic                          busy
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("ga25_sdr_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_t              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]      r_pending, w_pend_nxt, w_pick_req;
  logic [SDR_ADDR_W-1:0]   r_addr_q [NUM_REQ];
  logic [c_idx_w-1:0]      r_grant, r_ptr, w_pick_idx;
  logic                    w_pick_any;
  logic                    r_refresh_pend;
  logic                    w_grant_now, w_issue, w_capture, w_timeout, w_done;
  logic                    w_refresh_go;
  logic [NUM_REQ-1:0]      w_cl_rdy_nxt;
  logic [NUM_REQ-1:0]      r_cl_rdy;
  logic [SDR_DATA_W-1:0]   r_cl_data;
  logic [SDR_ADDR_W-1:0]   r_sdr_addr;
  logic                    r_sdr_req, r_sdr_refresh;

  // Requests arriving this very cycle compete alongside already-latched ones.
  assign w_pick_req = r_pending | cl_req;

  ga25_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_idx_w)
  ) u_picker (
    .req   (w_pick_req),
    .ptr   (r_ptr),
    .grant (w_pick_idx),
    .any   (w_pick_any)
  );

`ifdef GA25_ARB_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_timeout_seen;

  assign w_timeout = (r_state == ST_WAIT) && !sdr_rdy &&
                     (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_wait_cnt     <= '0;
      r_timeout_seen <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout)               r_timeout_seen <= 1'b1;
    end
  end

  assign timeout_seen = r_timeout_seen;
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_ram) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any)          w_state_nxt = ST_ISSUE;
        else if (r_refresh_pend) w_state_nxt = ST_REFRESH;
      end
      ST_ISSUE:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (sdr_rdy)        w_state_nxt = ST_RETURN;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_RETURN:  w_state_nxt = ST_IDLE;
      ST_REFRESH: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered outputs
  always_comb begin
    w_grant_now  = (r_state == ST_IDLE) && w_pick_any;
    w_issue      = (r_state == ST_ISSUE);
    w_capture    = (r_state == ST_WAIT) && sdr_rdy;
    w_done       = w_capture || w_timeout;
    w_refresh_go = (r_state == ST_IDLE) && !w_pick_any && r_refresh_pend;
    w_cl_rdy_nxt = w_done ? (NUM_REQ'(1) << r_grant) : '0;
    w_pend_nxt   = r_pending | cl_req;
    if (w_grant_now) w_pend_nxt[w_pick_idx] = 1'b0;
  end

  always_ff @(posedge clk_ram) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cl_req[i]) r_addr_q[i] <= cl_addr[SDR_ADDR_W*i +: SDR_ADDR_W];
    end
  end

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      r_pending      <= '0;
      r_refresh_pend <= 1'b0;
      r_grant        <= '0;
      r_ptr          <= '0;
      r_sdr_req      <= 1'b0;
      r_sdr_addr     <= '0;
      r_sdr_refresh  <= 1'b0;
      r_cl_rdy       <= '0;
      r_cl_data      <= '0;
    end else begin
      r_pending     <= w_pend_nxt;
      r_sdr_req     <= w_issue;
      r_sdr_refresh <= w_refresh_go;
      r_cl_rdy      <= w_cl_rdy_nxt;
      if (r_state == ST_REFRESH) r_refresh_pend <= |cl_refresh;
      else                       r_refresh_pend <= r_refresh_pend | (|cl_refresh);
      if (w_grant_now) r_grant    <= w_pick_idx;
      if (w_issue)     r_sdr_addr <= r_addr_q[r_grant];
      if (w_capture)      r_cl_data <= sdr_data;
      else if (w_timeout) r_cl_data <= '0;
      // Pointer moves past the client just served, whether by data or timeout.
      if (w_done) r_ptr <= (r_grant == c_idx_w'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign cl_rdy      = r_cl_rdy;
  assign cl_data     = r_cl_data;
  assign sdr_addr    = r_sdr_addr;
  assign sdr_req     = r_sdr_req;
  assign sdr_refresh = r_sdr_refresh;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ga25_sdr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ga25_sdr_arbiter
// Brief    : Directed self-checking bench for ga25_sdr_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_ga25_sdr_arbiter;

  logic        clk_ram = 1'b0;
  logic        reset   = 1'b1;
  logic [2:0]  cl_req  = '0;
  logic [74:0] cl_addr = '0;
  logic [2:0]  cl_refresh = '0;
  logic [2:0]  cl_rdy;
  logic [63:0] cl_data;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy  = 1'b0;
  logic [63:0] sdr_data = '0;
  logic        sdr_refresh;
  logic        busy;
`ifdef GA25_ARB_TIMEOUT_EN
  logic        timeout_seen;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_ram = ~clk_ram;

  ga25_sdr_arbiter #(.NUM_REQ(3), .TIMEOUT(16)) dut (
    .clk_ram     (clk_ram),
    .reset       (reset),
    .cl_req      (cl_req),
    .cl_addr     (cl_addr),
    .cl_refresh  (cl_refresh),
    .cl_rdy      (cl_rdy),
    .cl_data     (cl_data),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_rdy     (sdr_rdy),
    .sdr_data    (sdr_data),
    .sdr_refresh (sdr_refresh),
`ifdef GA25_ARB_TIMEOUT_EN
    .timeout_seen(timeout_seen),
`endif
    .busy        (busy)
  );

  task automatic tick;
    @(posedge clk_ram);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; cl_req = '0; cl_refresh = '0; sdr_rdy = 1'b0; cl_addr = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic request(input logic [2:0] mask, input logic [24:0] a0,
                         input logic [24:0] a1, input logic [24:0] a2);
    cl_req = mask;
    cl_addr[24:0] = a0; cl_addr[49:25] = a1; cl_addr[74:50] = a2;
    tick;
    cl_req = '0;
  endtask

  // Waits (bounded) for sdr_req, answers it, and reports what came back.
  task automatic serve(input logic [63:0] data, output logic [24:0] addr,
                       output logic [2:0] rdy, output logic [63:0] dout,
                       output bit ok, output int n_ref);
    ok = 1'b0; n_ref = 0; addr = '0; rdy = '0; dout = '0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (sdr_refresh) n_ref++;
      if (sdr_req) begin ok = 1'b1; addr = sdr_addr; break; end
    end
    if (ok) begin
      tick; if (sdr_refresh) n_ref++;
      tick; if (sdr_refresh) n_ref++;
      sdr_rdy = 1'b1; sdr_data = data;
      tick;
      sdr_rdy = 1'b0;
      rdy = cl_rdy; dout = cl_data;
    end
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if ({cl_rdy, cl_data, sdr_addr, sdr_req, sdr_refresh, busy} !== '0)
      $display("FAIL reset_outputs: got rdy=%b data=%h addr=%h req=%b ref=%b busy=%b, want all 0",
               cl_rdy, cl_data, sdr_addr, sdr_req, sdr_refresh, busy);
    else n_pass++;
    sdr_rdy = 1'b1; sdr_data = 64'h1234; tick; sdr_rdy = 1'b0; tick;
    n_checks++;
    if ({cl_rdy, busy, cl_data} !== '0)
      $display("FAIL idle_rdy_ignored: got rdy=%b busy=%b data=%h, want 0", cl_rdy, busy, cl_data);
    else n_pass++;
  endtask

  task automatic test_single;
    int n_early;
    do_reset;
    request(3'b010, 25'h0, 25'h012340, 25'h0);
    n_checks++;
    if (sdr_req !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_grant_cycle: got req=%b busy=%b, want req=0 busy=1", sdr_req, busy);
    else n_pass++;
    tick;
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 25'h012340)
      $display("FAIL single_issue: got req=%b addr=%h, want req=1 addr=012340", sdr_req, sdr_addr);
    else n_pass++;
    n_early = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 0 && sdr_req !== 1'b0) n_early++;
      if (cl_rdy !== 3'b000) n_early++;
    end
    n_checks++;
    if (n_early != 0) $display("FAIL single_wait_quiet: got %0d stray pulses, want 0", n_early);
    else n_pass++;
    sdr_rdy = 1'b1; sdr_data = 64'hDEADBEEF_00112233;
    tick;
    sdr_rdy = 1'b0;
    n_checks++;
    if (cl_rdy !== 3'b010 || cl_data !== 64'hDEADBEEF_00112233)
      $display("FAIL single_return: got rdy=%b data=%h, want rdy=010 data=deadbeef00112233", cl_rdy, cl_data);
    else n_pass++;
    tick;
    n_checks++;
    if (cl_rdy !== 3'b000 || cl_data !== 64'hDEADBEEF_00112233 || busy !== 1'b0 || sdr_addr !== 25'h012340)
      $display("FAIL single_after: got rdy=%b data=%h busy=%b addr=%h, want 000/deadbeef00112233/0/012340",
               cl_rdy, cl_data, busy, sdr_addr);
    else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [24:0] a; logic [2:0] r; logic [63:0] d; bit ok; int nr;
    logic [2:0]  exp_rdy [7];
    logic [24:0] exp_addr [7];
    exp_rdy  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_addr = '{25'h10, 25'h11, 25'h12, 25'h10, 25'h11, 25'h12, 25'h10};
    do_reset;
    request(3'b111, 25'h10, 25'h11, 25'h12);
    for (int k = 0; k < 7; k++) begin
      if (k == 3) request(3'b111, 25'h10, 25'h11, 25'h12);
      serve(64'hA000 + 64'(k), a, r, d, ok, nr);
      // Re-request everyone right after client 0's return in the second round.
      if (k == 3) begin
        cl_req = 3'b111; tick; cl_req = '0;
      end
      n_checks++;
      if (!ok || r !== exp_rdy[k] || a !== exp_addr[k] || d !== 64'hA000 + 64'(k))
        $display("FAIL rr_order[%0d]: got ok=%0d rdy=%b addr=%h data=%h, want rdy=%b addr=%h data=%h",
                 k, ok, r, a, d, exp_rdy[k], exp_addr[k], 64'hA000 + 64'(k));
      else n_pass++;
    end
  endtask

  task automatic test_addr_overwrite;
    logic [24:0] a; logic [2:0] r; logic [63:0] d; bit ok; int nr, extra;
    do_reset;
    request(3'b101, 25'h50, 25'h0, 25'h100);
    tick;
    n_checks++;
    if (sdr_req !== 1'b1 || sdr_addr !== 25'h50)
      $display("FAIL ovw_first_issue: got req=%b addr=%h, want 1/50", sdr_req, sdr_addr);
    else n_pass++;
    request(3'b100, 25'h0, 25'h0, 25'h200);
    sdr_rdy = 1'b1; sdr_data = 64'h55; tick; sdr_rdy = 1'b0;
    n_checks++;
    if (cl_rdy !== 3'b001) $display("FAIL ovw_client0: got rdy=%b, want 001", cl_rdy);
    else n_pass++;
    serve(64'h77, a, r, d, ok, nr);
    n_checks++;
    if (!ok || a !== 25'h200 || r !== 3'b100 || d !== 64'h77)
      $display("FAIL ovw_client2: got ok=%0d addr=%h rdy=%b data=%h, want addr=200 rdy=100 data=77", ok, a, r, d);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (sdr_req || cl_rdy !== 3'b000) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL ovw_no_second_read: got %0d extra pulses, want 0", extra);
    else n_pass++;
  endtask

  task automatic test_refresh;
    logic [24:0] a; logic [2:0] r; logic [63:0] d; bit ok; int nr, n_ref, n_rdy, n_req;
    do_reset;
    cl_refresh = 3'b001;
    request(3'b010, 25'h0, 25'h77, 25'h0);
    cl_refresh = '0;
    serve(64'hCAFE, a, r, d, ok, nr);
    n_checks++;
    if (!ok || a !== 25'h77 || r !== 3'b010 || nr != 0)
      $display("FAIL ref_read_first: got ok=%0d addr=%h rdy=%b early_ref=%0d, want addr=77 rdy=010 early_ref=0",
               ok, a, r, nr);
    else n_pass++;
    n_ref = 0; n_rdy = 0; n_req = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_rdy += int'(|cl_rdy);
      n_req += int'(sdr_req);
      if (sdr_refresh) begin n_ref++; sdr_rdy = 1'b1; sdr_data = 64'h99; end
      else sdr_rdy = 1'b0;
    end
    sdr_rdy = 1'b0;
    n_checks++;
    if (n_ref != 1 || n_rdy != 0 || n_req != 0 || busy !== 1'b0 || cl_data !== 64'hCAFE)
      $display("FAIL ref_pulse: got ref=%0d rdy=%0d req=%0d busy=%b data=%h, want 1/0/0/0/cafe",
               n_ref, n_rdy, n_req, busy, cl_data);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait;
    int bad;
    do_reset;
    request(3'b100, 25'h0, 25'h0, 25'h33);
    tick;
    n_checks++;
    if (sdr_req !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_wait_setup: got req=%b busy=%b, want 1/1", sdr_req, busy);
    else n_pass++;
    request(3'b001, 25'h44, 25'h0, 25'h0);
    reset = 1'b1; tick; reset = 1'b0;
    tick; tick;
    sdr_rdy = 1'b1; sdr_data = 64'hBAD; tick; sdr_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({cl_rdy, cl_data, sdr_addr, sdr_req, sdr_refresh, busy} !== '0) bad++;
      tick;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL rst_wait_quiet: got %0d nonzero-output cycles (busy=%b addr=%h data=%h), want 0",
               bad, busy, sdr_addr, cl_data);
    else n_pass++;
  endtask

`ifdef GA25_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [24:0] a; logic [2:0] r; logic [63:0] d; bit ok; int nr, n;
    do_reset;
    request(3'b010, 25'h0, 25'h61, 25'h0);
    serve(64'h1111, a, r, d, ok, nr);
    request(3'b001, 25'h62, 25'h0, 25'h0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin tick; ok = sdr_req; end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick; n++;
      if (cl_rdy !== 3'b000) break;
    end
    n_checks++;
    if (!ok || n != 16 || cl_rdy !== 3'b001 || cl_data !== 64'h0 || timeout_seen !== 1'b1)
      $display("FAIL timeout: got ok=%0d cycles=%0d rdy=%b data=%h seen=%b, want 16/001/0/1",
               ok, n, cl_rdy, cl_data, timeout_seen);
    else n_pass++;
    do_reset;
    n_checks++;
    if (timeout_seen !== 1'b0) $display("FAIL timeout_clear: got %b, want 0", timeout_seen);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_addr_overwrite;
    test_refresh;
    test_reset_in_wait;
`ifdef GA25_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ga25_sdr_arbiter.md
Name: ga25_sdr_arbiter

Overview:
- Shares the single 64-bit SDRAM graphics read channel among the GA25 fetch clients: object line fetcher, two tile-layer fetchers, and others up to NUM_REQ.
- Latches single-cycle client requests, grants round-robin, drives one outstanding SDRAM read at a time and routes the returned data and ready pulse back to the owning client.
- Merges client refresh hints into idle-time SDRAM refresh pulses.
- Runs entirely in the clk_ram domain; clients are synchronous to clk_ram.

Parameters:
- NUM_REQ, 3, number of requesting clients (2..8); index 0 = object fetcher.
- TIMEOUT, 255, cycles WAIT may last before abort (used only with the optional feature).

Ports:
- clk_ram  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- cl_req  in  NUM_REQ  per-client single-cycle request pulse.
- cl_addr  in  NUM_REQ*25  per-client 25-bit address; client i uses bits [25i+24:25i], sampled with cl_req[i].
- cl_refresh  in  NUM_REQ  per-client refresh hint pulse.
- cl_rdy  out  NUM_REQ  per-client one-cycle data-valid pulse.
- cl_data  out  64  returned burst data, valid with any cl_rdy bit.
- sdr_addr  out  25  SDRAM address.
- sdr_req  out  1  single-cycle SDRAM request pulse.
- sdr_rdy  in  1  SDRAM data-valid pulse.
- sdr_data  in  64  SDRAM read data.
- sdr_refresh  out  1  single-cycle refresh pulse.
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; pending[] and refresh_pend cleared.
  - Round-robin pointer set to client 0.
- Request capture: cl_req[i] high sets pending[i] and stores cl_addr slice i into addr_q[i].
  - A repeat request while pending overwrites addr_q[i] (latest address wins); no queueing.
- States: IDLE, ISSUE, WAIT, RETURN, REFRESH.
- IDLE: if any pending bit is set, or being set this cycle, pick a winner with ga25_rr_picker.
  - Search starts at the client after the last grant.
  - Latch grant index, clear pending[g], go to ISSUE.
  - Otherwise, if refresh_pend, go to REFRESH.
- ISSUE: drive sdr_addr = addr_q[g] and pulse sdr_req for exactly 1 cycle, then go to WAIT. sdr_addr holds until the next ISSUE.
- WAIT: on sdr_rdy, register sdr_data into cl_data and go to RETURN.
- RETURN: pulse cl_rdy[g] for 1 cycle, advance the pointer to g+1 (mod NUM_REQ), go to IDLE. cl_data holds until the next return.
- Latency: from cl_req to sdr_req is 2 cycles when idle (capture, grant); from sdr_rdy to cl_rdy is 1 cycle.
- A client re-requesting while its own read is in flight sets pending[g] again; it is served after the current read, in normal rotation.
- Refresh:
  - Any cl_refresh bit sets refresh_pend.
  - REFRESH pulses sdr_refresh for 1 cycle, clears refresh_pend (unless re-set the same cycle), returns to IDLE.
  - Pending reads always take priority over refresh.
- sdr_rdy in IDLE, ISSUE, REFRESH or RETURN is ignored (stale or late).
- Reset mid-transaction aborts it: no cl_rdy is issued and a later sdr_rdy is ignored.
- Fairness: with all clients continuously requesting, each is granted once per NUM_REQ transactions.

Optional Feature:
- GA25_ARB_TIMEOUT_EN defined:
  - An 8+ bit counter runs in WAIT.
  - When it reaches TIMEOUT without sdr_rdy: cl_data <= 64'h0, cl_rdy[g] pulses, sticky status bit timeout_seen (extra output port) sets, state goes to IDLE.
  - timeout_seen clears only on reset.
- Undefined: WAIT blocks indefinitely; no counter logic and no timeout_seen port.

Decomposition:
- board_pkg additions:
  - SDR_ADDR_W=25 and SDR_DATA_W=64 constants.
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RETURN, REFRESH}.
- Sub-module ga25_rr_picker: combinational rotating priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: grant index, any.
  - Instantiated once.

Test Plan:
- Single request: cl_req[1] with addr 25'h012340, sdr_rdy 5 cycles after sdr_req, sdr_data=64'hDEADBEEF_00112233 -> sdr_req 2 cycles after cl_req with sdr_addr=25'h012340; cl_rdy[1] 1 cycle after sdr_rdy with matching cl_data; no other cl_rdy bit high.
- Simultaneous requests from clients 0, 1 and 2, pointer at 0 -> grants in order 0, 1, 2. Re-requesting all three after client 0 returns gives order 1, 2, 0.
- Address overwrite: cl_req[2] addr 25'h100, then again addr 25'h200 while client 0 is in WAIT -> one read for client 2 at 25'h200; exactly one cl_rdy[2].
- Refresh vs read: cl_refresh[0] and cl_req[1] in the same cycle -> read issued first; sdr_refresh pulses once after cl_rdy[1]; sdr_rdy during REFRESH is ignored.
- Reset in WAIT: assert reset, then sdr_rdy 3 cycles later -> no cl_rdy; state IDLE, pending cleared, all outputs 0.
- GA25_ARB_TIMEOUT_EN with TIMEOUT=16 and no sdr_rdy -> cl_rdy[g] 16 cycles into WAIT with cl_data=0; timeout_seen=1 until reset.
